fb_plot_sink: RTL
=================

// Module: fb_plot_sink
// PURPOSE
//  Consumer end of the shape-drawer pixel-plot interface (x/y/colour/plot).
//  Accepts plot requests from circle/triangle drawers, bounds-checks them against the
//  160x120 screen, and writes them into an on-chip 3-bit framebuffer.
//  Also provides a hardware clear-screen engine and a registered read port for scan-out/readback.
// PARAMETERS
//  SCREEN_W  160  visible width in pixels
//  SCREEN_H  120  visible height in pixels
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  plot_x        in   8   pixel x coordinate
//  plot_y        in   7   pixel y coordinate
//  plot_colour   in   3   pixel colour
//  plot_valid    in   1   plot request
//  plot_ready    out  1   sink can accept; transfer when plot_valid && plot_ready
//  clear_start   in   1   begin clear-screen (sampled in IDLE only)
//  clear_colour  in   3   fill colour, latched on accepted clear_start
//  clear_busy    out  1   clear sequence in progress (DRAIN or CLEAR)
//  clear_done    out  1   one-cycle pulse when clear completes
//  rd_en         in   1   read request
//  rd_x          in   8   read x coordinate
//  rd_y          in   7   read y coordinate
//  rd_colour     out  3   read data, valid with rd_valid
//  rd_valid      out  1   high the cycle after rd_en
//  drop_cnt      out  8   off-screen plots accepted-and-discarded; saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE; plot_ready=1; clear_busy=0; clear_done=0; rd_valid=0; rd_colour=0; drop_cnt=0.
//  Framebuffer contents are not reset. Reset mid-clear aborts the clear; pixels already written keep their values.
//  Addressing: addr[14:0] = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x; no multiplier.
//  On-screen: x<SCREEN_W && y<SCREEN_H. Compare coordinates as unsigned.
//  Plot path, 2-stage:
//   - Cycle 0: accept and register {addr, colour, on_screen}.
//   - Cycle 1: write memory if on_screen; otherwise increment drop_cnt (saturating).
//   - Throughput: 1 plot/cycle.
//  Read path: rd_en at cycle N -> rd_colour/rd_valid at N+1.
//   - Off-screen read returns 3'b000.
//   - Read and write to the same address in the same cycle returns old data (read-first).
//   - Reads are always serviced, including during a clear.
//  FSM states: IDLE -> DRAIN -> CLEAR -> CDONE -> IDLE.
//   - IDLE: plot_ready=1. clear_start -> DRAIN and latch clear_colour. A plot accepted in the same cycle as clear_start is kept.
//   - DRAIN (1 cycle): plot_ready=0; pending stage-1 write retires.
//   - CLEAR: plot_ready=0; write clear_colour to addr 0..19199, one per cycle. Last address -> CDONE.
//   - CDONE (1 cycle): clear_done=1, plot_ready=0.
//   - clear_start outside IDLE is ignored.
//  Clear timing: clear_start at cycle 0 -> DRAIN at 1, CLEAR at 2..19201, clear_done at 19202, plot_ready=1 at 19203.
//  Single memory write port: the plot write (stage 1) and the clear write are never active in the same cycle, by construction.
// CONFIGURATION
//  FB_PLOT_COUNT_EN defined:
//   - adds output plot_cnt[15:0], counting on-screen pixel writes; saturates at 16'hFFFF.
//   - zeroed on reset and on an accepted clear_start.
//  FB_PLOT_COUNT_EN undefined: port and counter are absent.
// STRUCTURE
//  Package vga_pkg:
//   - SCREEN_W, SCREEN_H, FB_DEPTH=19200, FB_AW=15;
//   - typedef logic [2:0] colour_t; typedef logic [14:0] fb_addr_t;
//   - typedef enum {IDLE,DRAIN,CLEAR,CDONE} fb_state_t.
//  Sub-module fb_ram: simple dual-port 19200x3, one synchronous write port, one registered read port, read-first.
// TESTING
//  1. Plot (10,20,3'b101); rd_en (10,20) 3 cycles later -> next cycle rd_valid=1, rd_colour=3'b101.
//  2. Plot (160,0) then (0,120), both accepted -> no memory change; drop_cnt=2.
//  3. clear_start, clear_colour=3'b010 at cycle 0 -> clear_done pulse at 19202; reads of (0,0) and (159,119) return 3'b010.
//  4. plot_valid held with (5,5,3'b111) during clear -> accepted only at cycle 19203; pixel reads 3'b111, neighbours 3'b010.
//  5. rst_n low during CLEAR (near addr 5000) -> IDLE, plot_ready=1, clear_busy=0, drop_cnt=0; a new clear then completes normally.
//  6. 300 off-screen plots -> drop_cnt saturates at 255; with FB_PLOT_COUNT_EN, 50 on-screen plots -> plot_cnt=50.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the 160x120 3-bit framebuffer plot sink.
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_AW    = 15;

  typedef logic [2:0]       colour_t;
  typedef logic [FB_AW-1:0] fb_addr_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, CDONE} fb_state_t;

  typedef struct packed {
    fb_addr_t addr;
    colour_t  colour;
    logic     on_screen;
  } plot_req_t;

  // y*160 + x built from shifts so no multiplier is inferred.
  function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y);
    return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/fb_ram.sv
// 19200x3 simple dual-port framebuffer: one synchronous write port, one
// registered read port with read-first behaviour on address collision.
module fb_ram
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     i_we,
  input  fb_addr_t i_waddr,
  input  colour_t  i_wdata,
  input  logic     i_re,
  input  fb_addr_t i_raddr,
  output colour_t  o_rdata
);
  colour_t r_mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fb_plot_sink.sv
// Plot-interface sink: bounds check, 2-stage framebuffer write, clear engine, read port.
// Optional FB_PLOT_COUNT_EN adds a saturating on-screen write counter (plot_cnt).
module fb_plot_sink
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  colour_t     plot_colour,
  input  logic        plot_valid,
  output logic        plot_ready,
  input  logic        clear_start,
  input  colour_t     clear_colour,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        rd_en,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output colour_t     rd_colour,
  output logic        rd_valid,
`ifdef FB_PLOT_COUNT_EN
  output logic [15:0] plot_cnt,
`endif
  output logic [7:0]  drop_cnt
);
  fb_state_t r_state, w_next;
  plot_req_t r_s1;
  logic      r_s1_vld;
  colour_t   r_clr_col;
  fb_addr_t  r_clr_addr;
  logic      r_rd_vld, r_rd_on;
  logic [7:0] r_drop;

  logic     w_accept, w_on, w_rd_on, w_clr_go, w_clr_last, w_plot_we;
  logic     w_we;
  fb_addr_t w_waddr;
  colour_t  w_wdata, w_rd_q;

  assign w_accept   = plot_valid && plot_ready;
  assign w_on       = (plot_x < 8'(SCREEN_W)) && (plot_y < 7'(SCREEN_H));
  assign w_rd_on    = (rd_x < 8'(SCREEN_W)) && (rd_y < 7'(SCREEN_H));
  assign w_clr_go   = (r_state == IDLE) && clear_start;
  assign w_clr_last = (r_clr_addr == fb_addr_t'(FB_DEPTH - 1));
  assign w_plot_we  = r_s1_vld && r_s1.on_screen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    plot_ready = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (r_state)
      IDLE: begin
        plot_ready = 1'b1;
        if (clear_start) w_next = DRAIN;
      end
      DRAIN: begin
        clear_busy = 1'b1;
        w_next     = CLEAR;
      end
      CLEAR: begin
        clear_busy = 1'b1;
        if (w_clr_last) w_next = CDONE;
      end
      CDONE: begin
        clear_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1       <= '0;
      r_clr_col  <= '0;
      r_clr_addr <= '0;
      r_drop     <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_on    <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_s1 <= '{addr: fb_addr(plot_x, plot_y), colour: plot_colour, on_screen: w_on};
      if (w_clr_go) r_clr_col <= clear_colour;
      r_clr_addr <= (r_state == CLEAR) ? r_clr_addr + 15'd1 : '0;
      if (r_s1_vld && !r_s1.on_screen && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      r_rd_vld <= rd_en;
      r_rd_on  <= rd_en && w_rd_on;
    end
  end

`ifdef FB_PLOT_COUNT_EN
  logic [15:0] r_pcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_pcnt <= '0;
    else if (w_clr_go)                      r_pcnt <= '0;
    else if (w_plot_we && r_pcnt != 16'hFFFF) r_pcnt <= r_pcnt + 16'd1;
  end
  assign plot_cnt = r_pcnt;
`endif

  // Plot writes cannot reach stage 1 during CLEAR: ready was already low in DRAIN.
  assign w_we    = (r_state == CLEAR) || w_plot_we;
  assign w_waddr = (r_state == CLEAR) ? r_clr_addr : r_s1.addr;
  assign w_wdata = (r_state == CLEAR) ? r_clr_col  : r_s1.colour;

  fb_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (rd_en && w_rd_on),
    .i_raddr (fb_addr(rd_x, rd_y)),
    .o_rdata (w_rd_q)
  );

  assign rd_valid  = r_rd_vld;
  assign rd_colour = r_rd_on ? w_rd_q : '0;
  assign drop_cnt  = r_drop;
endmodule
